async_fifo_wr_arb: RTL and testbench

- Round-robin, packet-granular arbiter that shares the write side of one async_fifo between NUM_REQ requesters in the wclk domain.
- Each requester presents a valid/ready/last packet stream. A grant is held from the first beat to the last beat, so packets are never interleaved in the FIFO.
- Each FIFO entry carries the requester ID and a last flag, so the read-side consumer can demultiplex.

---
 rtl/async_fifo_arb_pkg.sv | 68 ++++++
 rtl/async_fifo_wr_arb_rr_arbiter.sv | 33 +++
 rtl/async_fifo_wr_arb.sv | 162 ++++++++++++++++
 tb/tb_async_fifo_wr_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_arb_pkg
// Shared types and helpers for the async FIFO write-side arbiter family.
//   - arb_state_e      : packet-arbiter FSM states
//   - rr_select()      : round-robin index search (up to RR_MAX_REQ requesters)
//   - beat_cnt_width() : width of a beat counter that can hold 0..max_beats
//   - FIFO word layout : {id, last, data} field positions and total width
// No ports (package).
// -----------------------------------------------------------------------------
package async_fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int RR_MAX_REQ = 16;
    localparam int RR_IDX_W   = 4;

    // Counter must represent MAX_BEATS itself, hence the +1.
    function automatic int beat_cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

    // FIFO word is packed as {id, last, data}.
    function automatic int fifo_word_width(input int data_w, input int id_w);
        return data_w + id_w + 1;
    endfunction

    function automatic int last_bit_pos(input int data_w);
        return data_w;
    endfunction

    function automatic int id_lsb_pos(input int data_w);
        return data_w + 1;
    endfunction

    // First set bit of valid, searching ptr, ptr+1, ... modulo num_req.
    // Returns 0 when nothing is valid; callers qualify with their own found flag.
    function automatic logic [RR_IDX_W-1:0] rr_select(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [RR_IDX_W-1:0]   ptr,
        input int                    num_req
    );
        logic [RR_IDX_W-1:0] sel;
        logic                found;
        int                  idx;
        sel   = {RR_IDX_W{1'b0}};
        found = 1'b0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end else begin
                idx = idx;
            end
            if ((i < num_req) && !found && valid[idx[RR_IDX_W-1:0]]) begin
                sel   = idx[RR_IDX_W-1:0];
                found = 1'b1;
            end else begin
                sel   = sel;
                found = found;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/async_fifo_wr_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority select, reusable by any block that shares
// a resource between up to 16 requesters.
//   valid_i [N]     : request vector
//   ptr_i   [IDX_W] : highest-priority index for this round
//   idx_o   [IDX_W] : selected index (meaningful only when found_o=1)
//   found_o         : at least one request is valid
// -----------------------------------------------------------------------------
module rr_arbiter
    import async_fifo_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [RR_MAX_REQ-1:0] valid_ext_s;

    // Zero-extend the request vector to the search width of rr_select.
    always_comb begin
        valid_ext_s          = {RR_MAX_REQ{1'b0}};
        valid_ext_s[N-1:0]   = valid_i;
    end

    assign idx_o   = IDX_W'(rr_select(valid_ext_s, RR_IDX_W'(ptr_i), N));
    assign found_o = |valid_i;

endmodule

// File: rtl/async_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_arb
// Packet-granular round-robin arbiter sharing one async FIFO write port between
// NUM_REQ requesters in the write-clock domain. A grant is held from first to
// last beat; packets longer than MAX_BEATS are cut with a forced last.
//   clk_i, reset_i          : write clock, synchronous active-high reset
//   req_valid/last/data_i   : per-requester beat stream (data k at k*DATA_WIDTH)
//   req_ready_o             : per-requester beat accept
//   fifo_wr_en_o/wdata_o    : FIFO write port, word = {id, last, data}
//   fifo_wfull/walmost_full : FIFO status
//   grant_o                 : one-hot owner, zero when idle
//   busy_o                  : packet in progress
//   overlen_o               : one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module async_fifo_wr_arb
    import async_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 2,
    parameter int MAX_BEATS  = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH+ID_WIDTH:0]  fifo_wdata_o,
    input  logic                          fifo_wfull_i,
    input  logic                          fifo_walmost_full_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          overlen_o
);

    localparam int CNT_W    = beat_cnt_width(MAX_BEATS);
    localparam int WORD_W   = fifo_word_width(DATA_WIDTH, ID_WIDTH);
    localparam int LAST_POS = last_bit_pos(DATA_WIDTH);
    localparam int ID_LSB   = id_lsb_pos(DATA_WIDTH);

    arb_state_e              state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [ID_WIDTH-1:0]     owner_q, owner_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    overlen_q, overlen_d;

    logic [ID_WIDTH-1:0]     win_idx_s;
    logic                    win_found_s;
    logic                    owner_valid_s;
    logic                    owner_last_s;
    logic [DATA_WIDTH-1:0]   owner_data_s;
    logic                    eff_last_s;
    logic [WORD_W-1:0]       wdata_s;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_WIDTH)
    ) u_rr_arbiter (
        .valid_i (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (win_idx_s),
        .found_o (win_found_s)
    );

    // Owner's beat fields selected by the one-hot grant (AND-OR mux).
    always_comb begin
        owner_data_s = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            owner_data_s = owner_data_s |
                           (req_data_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[k]}});
        end
    end

    assign owner_valid_s = |(req_valid_i & grant_q);
    assign owner_last_s  = |(req_last_i & grant_q);
    // Forced last when the beat being presented is the MAX_BEATS-th of the packet.
    assign eff_last_s    = owner_last_s | (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

    // FSM next state, beat counter, handshakes and FIFO word.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        overlen_d    = 1'b0;
        req_ready_o  = {NUM_REQ{1'b0}};
        fifo_wr_en_o = 1'b0;
        wdata_s      = {WORD_W{1'b0}};
        case (state_q)
            IDLE: begin
                // Almost-full gates only the start of a packet.
                if (win_found_s && !fifo_walmost_full_i) begin
                    state_d    = GRANT;
                    grant_d    = NUM_REQ'(1) << win_idx_s;
                    owner_d    = win_idx_s;
                    beat_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d    = IDLE;
                end
            end
            GRANT: begin
                req_ready_o                       = grant_q & {NUM_REQ{~fifo_wfull_i}};
                fifo_wr_en_o                      = owner_valid_s & ~fifo_wfull_i;
                wdata_s[DATA_WIDTH-1:0]           = owner_data_s;
                wdata_s[LAST_POS]                 = eff_last_s;
                wdata_s[ID_LSB +: ID_WIDTH]       = owner_q;
                if (owner_valid_s && !fifo_wfull_i) begin
                    if (eff_last_s) begin
                        state_d    = IDLE;
                        grant_d    = {NUM_REQ{1'b0}};
                        beat_cnt_d = {CNT_W{1'b0}};
                        overlen_d  = ~owner_last_s;
                        if (owner_q == ID_WIDTH'(NUM_REQ - 1)) begin
                            rr_ptr_d = {ID_WIDTH{1'b0}};
                        end else begin
                            rr_ptr_d = owner_q + ID_WIDTH'(1);
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Stall or bubble: hold everything.
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = {NUM_REQ{1'b0}};
                beat_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            grant_q    <= {NUM_REQ{1'b0}};
            owner_q    <= {ID_WIDTH{1'b0}};
            rr_ptr_q   <= {ID_WIDTH{1'b0}};
            beat_cnt_q <= {CNT_W{1'b0}};
            overlen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            overlen_q  <= overlen_d;
        end
    end

    assign fifo_wdata_o = wdata_s;
    assign grant_o      = grant_q;
    assign busy_o       = (state_q == GRANT);
    assign overlen_o    = overlen_q;

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_wr_arb
// Directed scenarios followed by randomized traffic. Every cycle the DUT ports
// are compared with a packet-level reference model (owner / pointer / beat
// count as plain integers); scenario-specific results are also checked against
// literal expectations from the FIFO write log.
// -----------------------------------------------------------------------------
module tb_async_fifo_wr_arb;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int IW = 2;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     v, l;
    logic [NR*DW-1:0]  dbus;
    logic              wf, af;
    logic [NR-1:0]     ready, grant;
    logic              wr, busy, ovl;
    logic [DW+IW:0]    wdata;

    int checks = 0;
    int errors = 0;

    int   m_owner, m_ptr, m_beats;
    bit   m_ovl;
    logic [DW+IW:0] wlog[$];
    int   wcyc[$];
    int   ncyc = 0;
    int   ovl_cnt = 0;
    int   n;
    logic [NR-1:0] obs_grant, obs_ready;
    logic obs_wr, obs_busy, obs_ovl;
    logic [DW+IW:0] exp_word;

    always #5 clk = ~clk;

    async_fifo_wr_arb #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BEATS(MB)
    ) dut (
        .clk_i               (clk),
        .reset_i             (rst),
        .req_valid_i         (v),
        .req_last_i          (l),
        .req_data_i          (dbus),
        .req_ready_o         (ready),
        .fifo_wr_en_o        (wr),
        .fifo_wdata_o        (wdata),
        .fifo_wfull_i        (wf),
        .fifo_walmost_full_i (af),
        .grant_o             (grant),
        .busy_o              (busy),
        .overlen_o           (ovl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat(input int k);
        if (k < 0) return '0;
        return dbus[k*DW +: DW];
    endfunction

    task automatic set_d(input int k, input logic [DW-1:0] val);
        dbus[k*DW +: DW] = val;
    endtask

    // One clock: check ports against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic [NR-1:0]  eg, er;
        logic           ew, el;
        logic [DW+IW:0] ewd;
        int             k;
        #1;
        eg  = (m_owner < 0) ? '0 : NR'(1 << m_owner);
        ew  = (m_owner >= 0) ? (v[m_owner] && !wf) : 1'b0;
        el  = (m_owner >= 0) ? (l[m_owner] || (m_beats == MB - 1)) : 1'b0;
        er  = wf ? '0 : eg;
        ewd = {IW'(m_owner), el, dat(m_owner)};
        chk("grant",   grant, eg);
        chk("busy",    busy,  m_owner >= 0);
        chk("overlen", ovl,   m_ovl);
        chk("ready",   ready, er);
        chk("wr_en",   wr,    ew);
        if (ew) chk("wdata", wdata, ewd);
        obs_grant = grant; obs_ready = ready; obs_wr = wr; obs_busy = busy; obs_ovl = ovl;
        if (wr) begin
            wlog.push_back(wdata);
            wcyc.push_back(ncyc);
        end
        if (ovl) ovl_cnt++;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_beats = 0; m_ovl = 0;
        end else if (m_owner < 0) begin
            m_ovl = 0;
            if (!af && (v != '0)) begin
                for (int i = NR - 1; i >= 0; i--) begin
                    k = (m_ptr + i) % NR;
                    if (v[k]) m_owner = k;
                end
                m_beats = 0;
            end
        end else begin
            m_ovl = 0;
            if (ew) begin
                if (el) begin
                    m_ovl   = !l[m_owner];
                    m_ptr   = (m_owner + 1) % NR;
                    m_owner = -1;
                    m_beats = 0;
                end else begin
                    m_beats++;
                end
            end
        end
        ncyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; v = '0; l = '0; dbus = '0; wf = 1'b0; af = 1'b0;
        m_owner = -1; m_ptr = 0; m_beats = 0; m_ovl = 0;
        @(negedge clk);

        // Reset for three cycles.
        repeat (3) cycle();
        chk("rst_grant", obs_grant, 4'b0000);
        chk("rst_busy",  obs_busy,  1'b0);
        chk("rst_ready", obs_ready, 4'b0000);
        chk("rst_wr",    obs_wr,    1'b0);
        rst = 1'b0;

        // Single 3-beat packet from requester 2.
        wlog.delete();
        v = 4'b0100; set_d(2, 16'h00A1);
        cycle();
        chk("t1_arb_grant", obs_grant, 4'b0000);
        cycle();
        chk("t1_grant", obs_grant, 4'b0100);
        set_d(2, 16'h00A2); cycle();
        set_d(2, 16'h00A3); l = 4'b0100; cycle();
        v = '0; l = '0; cycle();
        chk("t1_idle_grant", obs_grant, 4'b0000);
        chk("t1_idle_busy",  obs_busy,  1'b0);
        chk("t1_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("t1_w0", wlog[0], 19'h400A1);
            chk("t1_w1", wlog[1], 19'h400A2);
            chk("t1_w2", wlog[2], 19'h500A3);
        end
        // Pointer now at 3: requester 3 beats requester 2.
        v = 4'b1100; l = 4'b1100; set_d(3, 16'h0033);
        cycle(); cycle();
        chk("t1_ptr3_grant", obs_grant, 4'b1000);
        v = '0; l = '0; cycle();

        // Round-robin from reset: all valid, 1-beat packets.
        rst = 1'b1; cycle(); rst = 1'b0;
        wlog.delete(); wcyc.delete();
        v = 4'b1111; l = 4'b1111;
        for (int k = 0; k < NR; k++) set_d(k, 16'h00B0 + 16'(k));
        repeat (10) cycle();
        v = '0; l = '0; cycle();
        chk("rr_nwrites", wlog.size(), 5);
        for (int i = 0; i < 5 && i < wlog.size(); i++)
            chk("rr_id", wlog[i][DW+IW:DW+1], i % NR);
        for (int i = 0; i + 1 < wcyc.size(); i++)
            chk("rr_gap", wcyc[i+1] - wcyc[i], 2);

        // Backpressure in a 4-beat packet from requester 1 (pointer is 1).
        wlog.delete();
        v = 4'b0010; set_d(1, 16'h00B1);
        cycle(); cycle();
        set_d(1, 16'h00B2); wf = 1'b1;
        repeat (5) begin
            cycle();
            chk("bp_wr",    obs_wr,    1'b0);
            chk("bp_ready", obs_ready, 4'b0000);
            chk("bp_grant", obs_grant, 4'b0010);
        end
        wf = 1'b0; cycle();
        set_d(1, 16'h00B3); cycle();
        set_d(1, 16'h00B4); l = 4'b0010; cycle();
        v = '0; l = '0; cycle();
        chk("bp_nwrites", wlog.size(), 4);
        if (wlog.size() == 4) begin
            chk("bp_w0", wlog[0], 19'h200B1);
            chk("bp_w1", wlog[1], 19'h200B2);
            chk("bp_w2", wlog[2], 19'h200B3);
            chk("bp_w3", wlog[3], 19'h300B4);
        end

        // Almost-full holds off a new packet but not one in progress.
        af = 1'b1; v = 4'b0001; set_d(0, 16'h00D1);
        repeat (6) begin
            cycle();
            chk("af_hold", obs_grant, 4'b0000);
        end
        af = 1'b0; cycle();
        cycle();
        chk("af_grant", obs_grant, 4'b0001);
        chk("af_wr0",   obs_wr,    1'b1);
        af = 1'b1; set_d(0, 16'h00D2); cycle();
        chk("af_wr1", obs_wr, 1'b1);
        set_d(0, 16'h00D3); l = 4'b0001; cycle();
        chk("af_wr2", obs_wr, 1'b1);
        v = '0; l = '0; af = 1'b0; cycle();

        // Overlength: 6 beats without last from requester 3.
        wlog.delete(); ovl_cnt = 0; n = 0;
        v = 4'b1000;
        for (int t = 0; t < 14 && n < 6; t++) begin
            set_d(3, 16'h00C1 + 16'(n));
            cycle();
            if (obs_wr) n++;
        end
        chk("ovl_beats", n, 6);
        v = '0; cycle(); cycle();
        chk("ovl_bubble_grant", obs_grant, 4'b1000);
        chk("ovl_pulses", ovl_cnt, 1);
        chk("ovl_nwrites", wlog.size(), 6);
        for (int i = 0; i < 6 && i < wlog.size(); i++) begin
            exp_word = {2'd3, (i == 3) ? 1'b1 : 1'b0, 16'h00C1 + 16'(i)};
            chk("ovl_word", wlog[i], exp_word);
        end

        // Reset mid-packet (requester 3 holds a 2-beat partial packet).
        rst = 1'b1; cycle();
        rst = 1'b0; cycle();
        chk("mr_grant", obs_grant, 4'b0000);
        chk("mr_busy",  obs_busy,  1'b0);
        chk("mr_ready", obs_ready, 4'b0000);
        chk("mr_wr",    obs_wr,    1'b0);
        chk("mr_ovl",   obs_ovl,   1'b0);
        v = 4'b1010; l = 4'b1010;
        cycle(); cycle();
        chk("mr_regrant", obs_grant, 4'b0010);
        v = '0; l = '0; cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(63) == 0);
            v   = NR'($urandom);
            for (int k = 0; k < NR; k++) l[k] = ($urandom_range(3) == 0);
            dbus = {$urandom, $urandom};
            wf  = ($urandom_range(3) == 0);
            af  = ($urandom_range(3) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
